alu_pipelined: RTL
==================

// Module: alu_pipelined
// PURPOSE
//  Next-generation parametrised ALU with a valid/ready handshake on input and output, a
//  multi-cycle iterative divider, status flags and an extended opcode set. Sits between
//  the register-file/control FSM and the result write-back path; one operation in flight
//  at a time, single-cycle ops sustain one result per clock when the consumer is ready.
// PARAMETERS
//  DATA_WIDTH  8  operand width W (>=4); ALU_result is 2*W bits
// PORTS
//  clk               in   1     rising-edge clock, only clock domain
//  reset             in   1     asynchronous, active-high reset
//  in_valid          in   1     operands/opcode valid
//  in_ready          out  1     block can accept operation this cycle
//  A                 in   W     operand A (unsigned)
//  B                 in   W     operand B (unsigned)
//  ALU_function      in   4     opcode (see BEHAVIOUR)
//  ALU_result_valid  out  1     result/flags valid
//  ALU_result_ready  in   1     consumer takes result this cycle
//  ALU_result        out  2W    result
//  carry             out  1     ADD carry-out / SUB borrow, else 0
//  zero              out  1     ALU_result == 0
//  error             out  1     divide-by-zero or illegal opcode
//  busy              out  1     divider iterating
// BEHAVIOUR
//  Opcodes (A,B zero-extended to 2W before arithmetic):
//   0 ADD A+B | 1 SUB A-B mod 2^(2W) | 2 MUL full product | 3 DIV {rem,quot}
//   4 AND | 5 OR | 6 NAND | 7 NOR | 8 XOR | 9 XNOR (logic: {W'b0, op})
//   A CMP_EQ | B CMP_GT | C CMP_LT (result 1 or 0 in bit 0)
//   D SHL A<<B | E SHR A>>B (shift of W-bit A, zero-filled, {W'b0,res}; B>=W -> 0)
//   F illegal: result 0, error=1, zero=1
//  State machine: IDLE (output reg empty) / BUSY (divide iterating) / HOLD (result valid).
//  Accept = in_valid & in_ready. in_ready = (IDLE) | (HOLD & ALU_result_ready);
//   combinational path ALU_result_ready -> in_ready is intended.
//  Single-cycle ops: accepted on edge N -> ALU_result_valid=1 with result after edge N; -> HOLD.
//  DIV: restoring, one quotient bit per clock, operands latched on accept; -> BUSY, busy=1,
//   in_ready=0; ALU_result_valid=1 after edge N+W; -> HOLD. Latency W cycles.
//  DIV by zero: no iteration, 1-cycle latency, result {A, all-ones quotient}, error=1.
//  HOLD: ALU_result and flags stable while ALU_result_ready=0. Drain with no new accept -> IDLE;
//   drain + simultaneous accept -> new op (HOLD or BUSY) with no bubble.
//  Flags registered with result; carry = bit W of ADD sum, or (A<B) for SUB; 0 otherwise.
//  Inputs ignored when not accepted; changing A/B/opcode during BUSY has no effect.
//  Reset (any state, incl. mid-divide): state IDLE, ALU_result=0, ALU_result_valid=0,
//   carry=0, zero=0, error=0, busy=0; divider state cleared; no stale result afterwards.
// TESTING (W=8)
//  ADD A=54 B=2A -> 007E, carry=0, valid 1 cycle after accept; A=FF B=01 -> 0100, carry=1.
//  SUB A=2A B=54 -> FFD6, carry=1; MUL A=54 B=2A -> 0DC8; AND A=54 B=2F -> 0004; SHL A=81 B=1 -> 0002.
//  DIV A=C8 B=07 -> 041C, busy 8 cycles, valid exactly 8 cycles after accept; B=0 -> 54FF, error=1.
//  Backpressure: ALU_result_ready=0 for 5 cycles after ADD -> 007E stable, in_ready=0; then
//   ALU_result_ready=1 with new ADD presented -> same-edge drain+accept, next result next cycle.
//  Back-to-back single-cycle ops with ALU_result_ready=1 -> one result per clock, none dropped.
//  reset asserted on cycle 3 of a DIV -> ALU_result_valid=0, busy=0, in_ready=1 after release; opcode F -> error=1.

Source files
------------

// File: rtl/alu_pipelined_if.sv
// Handshake and data bundle for alu_pipelined: operation request channel and
// result channel with status flags.
interface alu_pipelined_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     A;
    logic [DATA_WIDTH-1:0]     B;
    logic [3:0]                ALU_function;
    logic                      ALU_result_valid;
    logic                      ALU_result_ready;
    logic [2*DATA_WIDTH-1:0]   ALU_result;
    logic                      carry;
    logic                      zero;
    logic                      error;
    logic                      busy;

    modport master (
        output in_valid, A, B, ALU_function, ALU_result_ready,
        input  in_ready, ALU_result_valid, ALU_result, carry, zero, error, busy
    );

    modport slave (
        input  in_valid, A, B, ALU_function, ALU_result_ready,
        output in_ready, ALU_result_valid, ALU_result, carry, zero, error, busy
    );
endinterface

// File: rtl/alu_pipelined.sv
// Handshaked ALU: single-cycle arithmetic/logic ops plus a restoring divider
// that produces one quotient bit per clock. One operation in flight at a time.
//
// state | meaning
// IDLE  | output register empty, ready for a new operation
// BUSY  | divider iterating, inputs not accepted
// HOLD  | result and flags valid, waiting for the consumer
module alu_pipelined #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_pipelined_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] W_LIM = W'(W);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_EQ   = 4'hA;
    localparam logic [3:0] OP_GT   = 4'hB;
    localparam logic [3:0] OP_LT   = 4'hC;
    localparam logic [3:0] OP_SHL  = 4'hD;
    localparam logic [3:0] OP_SHR  = 4'hE;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t          state;
    logic [2*W-1:0]  result_q;
    logic            carry_q;
    logic            zero_q;
    logic            error_q;
    logic            valid_q;
    logic            busy_q;

    logic [W-1:0]    div_rem;
    logic [W-1:0]    div_quot;
    logic [W-1:0]    div_den;
    logic [CW-1:0]   div_cnt;

    logic            in_ready;
    logic            accept;

    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  b_ext;
    logic [2*W-1:0]  sum;
    logic [2*W-1:0]  diff;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    shl;
    logic [W-1:0]    shr;
    logic [2*W-1:0]  op_res;
    logic            op_carry;
    logic            op_error;
    logic            div_iter;

    logic [W:0]      rem_shift;
    logic            rem_ge;
    logic [W-1:0]    rem_next;
    logic [W-1:0]    quot_next;

    // in_ready depends combinationally on ALU_result_ready so a drain and a
    // new accept can share one edge.
    assign in_ready = (state == IDLE) || ((state == HOLD) && bus.ALU_result_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready         = in_ready;
    assign bus.ALU_result_valid = valid_q;
    assign bus.ALU_result       = result_q;
    assign bus.carry            = carry_q;
    assign bus.zero             = zero_q;
    assign bus.error            = error_q;
    assign bus.busy             = busy_q;

    always_comb begin
        a_ext    = {{W{1'b0}}, bus.A};
        b_ext    = {{W{1'b0}}, bus.B};
        sum      = a_ext + b_ext;
        diff     = a_ext - b_ext;
        prod     = a_ext * b_ext;
        shl      = (bus.B >= W_LIM) ? '0 : (bus.A << bus.B);
        shr      = (bus.B >= W_LIM) ? '0 : (bus.A >> bus.B);
        op_res   = '0;
        op_carry = 1'b0;
        op_error = 1'b0;
        div_iter = (bus.ALU_function == OP_DIV) && (bus.B != '0);
        case (bus.ALU_function)
            OP_ADD: begin
                op_res   = sum;
                op_carry = sum[W];
            end
            OP_SUB: begin
                op_res   = diff;
                op_carry = (bus.A < bus.B);
            end
            OP_MUL:  op_res = prod;
            // Only reached for a zero divisor; non-zero divisors iterate.
            OP_DIV: begin
                op_res   = {bus.A, {W{1'b1}}};
                op_error = 1'b1;
            end
            OP_AND:  op_res = {{W{1'b0}}, bus.A & bus.B};
            OP_OR:   op_res = {{W{1'b0}}, bus.A | bus.B};
            OP_NAND: op_res = {{W{1'b0}}, ~(bus.A & bus.B)};
            OP_NOR:  op_res = {{W{1'b0}}, ~(bus.A | bus.B)};
            OP_XOR:  op_res = {{W{1'b0}}, bus.A ^ bus.B};
            OP_XNOR: op_res = {{W{1'b0}}, ~(bus.A ^ bus.B)};
            OP_EQ:   op_res = {{(2*W-1){1'b0}}, bus.A == bus.B};
            OP_GT:   op_res = {{(2*W-1){1'b0}}, bus.A > bus.B};
            OP_LT:   op_res = {{(2*W-1){1'b0}}, bus.A < bus.B};
            OP_SHL:  op_res = {{W{1'b0}}, shl};
            OP_SHR:  op_res = {{W{1'b0}}, shr};
            default: op_error = 1'b1;
        endcase
    end

    // Restoring step: dividend bits leave the top of div_quot as quotient
    // bits enter at the bottom.
    always_comb begin
        rem_shift = {div_rem, div_quot[W-1]};
        rem_ge    = (rem_shift >= {1'b0, div_den});
        rem_next  = rem_ge ? (rem_shift[W-1:0] - div_den) : rem_shift[W-1:0];
        quot_next = {div_quot[W-2:0], rem_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            div_rem  <= '0;
            div_quot <= '0;
            div_den  <= '0;
            div_cnt  <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (div_iter) begin
                            state    <= BUSY;
                            valid_q  <= 1'b0;
                            busy_q   <= 1'b1;
                            div_rem  <= '0;
                            div_quot <= bus.A;
                            div_den  <= bus.B;
                            div_cnt  <= CW'(W);
                        end else begin
                            state    <= HOLD;
                            valid_q  <= 1'b1;
                            result_q <= op_res;
                            carry_q  <= op_carry;
                            zero_q   <= (op_res == '0);
                            error_q  <= op_error;
                        end
                    end else if ((state == HOLD) && bus.ALU_result_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    div_rem  <= rem_next;
                    div_quot <= quot_next;
                    div_cnt  <= div_cnt - 1'b1;
                    if (div_cnt == CW'(1)) begin
                        state    <= HOLD;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        result_q <= {rem_next, quot_next};
                        carry_q  <= 1'b0;
                        zero_q   <= ({rem_next, quot_next} == '0);
                        error_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
